// File: rtl/lv_flt_mgr_pkg.sv
// rtl/lv_flt_mgr_pkg.sv - shared state encoding for the LV fault manager
package lv_flt_mgr_pkg;

   localparam int LV_ST_W = 3;

   typedef enum logic [LV_ST_W-1:0] {
      ST_IDLE     = 3'd0,
      ST_RUN      = 3'd1,
      ST_FAULT    = 3'd2,
      ST_RECOVER  = 3'd3,
      ST_FAILSAFE = 3'd4
   } lv_st_e;

endpackage

// File: rtl/lv_err_deb.sv
// rtl/lv_err_deb.sv - per-source debounce; qualifies a raw error after DEB_CYC consecutive high cycles
module lv_err_deb #(
   parameter int DEB_CYC = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_err,
   output logic o_q
);

   localparam int            DW      = $clog2(DEB_CYC + 1);
   localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYC);

   logic [DW-1:0] cnt;

   // Saturates at DEB_MAX so a long-held error stays qualified without wrapping.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         cnt <= '0;
      else if (!i_err)
         cnt <= '0;
      else if (cnt != DEB_MAX)
         cnt <= cnt + 1'b1;
   end

   assign o_q = (cnt == DEB_MAX);

endmodule

// File: rtl/lv_flt_mgr.sv
// rtl/lv_flt_mgr.sv - LV fault manager: debounced error sources, sticky status and run/fault/failsafe FSM
module lv_flt_mgr
   import lv_flt_mgr_pkg::*;
#(
   parameter int ERR_NUM = 16,
   parameter int DEB_CYC = 4,
   parameter int REC_CYC = 64
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_run_en,
   input  logic               i_fsenb_n,
   input  logic [ERR_NUM-1:0] i_err,
   input  logic [ERR_NUM-1:0] i_err_mask,
   input  logic [ERR_NUM-1:0] i_err_fatal,
   input  logic [ERR_NUM-1:0] i_err_clr,
   output logic [ERR_NUM-1:0] o_err_sts,
   output logic [LV_ST_W-1:0] o_st,
   output logic               o_pwm_en,
   output logic               o_fsafe_en,
   output logic               o_int_n
);

   localparam int            RW      = $clog2(REC_CYC + 1);
   localparam logic [RW-1:0] REC_MAX = RW'(REC_CYC);

   logic [ERR_NUM-1:0] q;
   logic [ERR_NUM-1:0] uq;
   logic               any_uq;
   logic               fatal_held;
   logic [RW-1:0]      rec_cnt;
   logic [RW-1:0]      rec_nxt;
   lv_st_e             cur_st;

   for (genvar g = 0; g < ERR_NUM; g++) begin : g_deb
      lv_err_deb #(.DEB_CYC(DEB_CYC)) u_deb (
         .i_clk   (i_clk),
         .i_rst_n (i_rst_n),
         .i_err   (i_err[g]),
         .o_q     (q[g])
      );
   end

   assign uq         = q & ~i_err_mask;
   assign any_uq     = |uq;
   assign fatal_held = |(o_err_sts & i_err_fatal);
   assign rec_nxt    = rec_cnt + 1'b1;
   assign o_st       = cur_st;

   // Set wins over a coincident clear; masking never clears an already-set bit.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         o_err_sts <= '0;
      else
         o_err_sts <= (o_err_sts & ~i_err_clr) | uq;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cur_st     <= ST_IDLE;
         rec_cnt    <= '0;
         o_pwm_en   <= 1'b0;
         o_fsafe_en <= 1'b0;
         o_int_n    <= 1'b1;
      end else begin
         o_pwm_en   <= (cur_st == ST_RUN);
         o_fsafe_en <= (cur_st == ST_FAILSAFE);
         o_int_n    <= ~((|o_err_sts) | (cur_st == ST_FAILSAFE));
         rec_cnt    <= '0;
         case (cur_st)
            ST_IDLE: begin
               if (!i_fsenb_n)    cur_st <= ST_FAILSAFE;
               else if (any_uq)   cur_st <= ST_FAULT;
               else if (i_run_en) cur_st <= ST_RUN;
            end
            ST_RUN: begin
               if (!i_fsenb_n)     cur_st <= ST_FAILSAFE;
               else if (any_uq)    cur_st <= ST_FAULT;
               else if (!i_run_en) cur_st <= ST_IDLE;
            end
            ST_FAULT: begin
               if (!i_fsenb_n)                   cur_st <= ST_FAILSAFE;
               else if (!any_uq && !fatal_held)  cur_st <= ST_RECOVER;
            end
            ST_RECOVER: begin
               if (!i_fsenb_n)               cur_st <= ST_FAILSAFE;
               else if (any_uq)              cur_st <= ST_FAULT;
               else if (rec_nxt == REC_MAX)  cur_st <= i_run_en ? ST_RUN : ST_IDLE;
               else                          rec_cnt <= rec_nxt;
            end
            ST_FAILSAFE: begin
               if (i_fsenb_n && !any_uq) cur_st <= ST_IDLE;
            end
            default: cur_st <= ST_FAILSAFE;
         endcase
      end
   end

endmodule

// File: tb/tb_lv_flt_mgr.sv
// tb/tb_lv_flt_mgr.sv - directed and randomized checks of lv_flt_mgr against a behavioural model
module tb_lv_flt_mgr;

   localparam int N   = 16;
   localparam int DEB = 4;
   localparam int REC = 8;

   localparam int S_IDLE = 0;
   localparam int S_RUN  = 1;
   localparam int S_FLT  = 2;
   localparam int S_REC  = 3;
   localparam int S_FS   = 4;

   logic         i_clk = 1'b0;
   logic         i_rst_n;
   logic         i_run_en;
   logic         i_fsenb_n;
   logic [N-1:0] i_err;
   logic [N-1:0] i_err_mask;
   logic [N-1:0] i_err_fatal;
   logic [N-1:0] i_err_clr;
   logic [N-1:0] o_err_sts;
   logic [2:0]   o_st;
   logic         o_pwm_en;
   logic         o_fsafe_en;
   logic         o_int_n;

   int n_pass = 0;
   int n_tot  = 0;

   int           m_st;
   int           m_rec;
   logic [N-1:0] m_sts;
   logic         m_pwm;
   logic         m_fs;
   logic         m_intn;
   int           run_len [N];

   lv_flt_mgr #(.ERR_NUM(N), .DEB_CYC(DEB), .REC_CYC(REC)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_run_en    (i_run_en),
      .i_fsenb_n   (i_fsenb_n),
      .i_err       (i_err),
      .i_err_mask  (i_err_mask),
      .i_err_fatal (i_err_fatal),
      .i_err_clr   (i_err_clr),
      .o_err_sts   (o_err_sts),
      .o_st        (o_st),
      .o_pwm_en    (o_pwm_en),
      .o_fsafe_en  (o_fsafe_en),
      .o_int_n     (o_int_n)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
   endtask

   function automatic void m_reset();
      m_st   = S_IDLE;
      m_rec  = 0;
      m_sts  = '0;
      m_pwm  = 1'b0;
      m_fs   = 1'b0;
      m_intn = 1'b1;
      for (int i = 0; i < N; i++) run_len[i] = 0;
   endfunction

   // One clock of the rules: an error counts once it has been seen high DEB times in a row.
   function automatic void m_step();
      logic [N-1:0] q;
      logic [N-1:0] uq;
      int nst;
      int nrec;
      for (int i = 0; i < N; i++) q[i] = (run_len[i] >= DEB);
      uq   = q & ~i_err_mask;
      nst  = m_st;
      nrec = 0;
      if (m_st == S_FS) begin
         if (i_fsenb_n && uq == '0) nst = S_IDLE;
      end else if (!i_fsenb_n) begin
         nst = S_FS;
      end else if (uq != '0 && m_st != S_FLT) begin
         nst = S_FLT;
      end else if (m_st == S_IDLE) begin
         if (i_run_en) nst = S_RUN;
      end else if (m_st == S_RUN) begin
         if (!i_run_en) nst = S_IDLE;
      end else if (m_st == S_FLT) begin
         if (uq == '0 && (m_sts & i_err_fatal) == '0) nst = S_REC;
      end else if (m_st == S_REC) begin
         if (m_rec + 1 >= REC) nst = i_run_en ? S_RUN : S_IDLE;
         else nrec = m_rec + 1;
      end else begin
         nst = S_FS;
      end
      m_pwm  = (m_st == S_RUN);
      m_fs   = (m_st == S_FS);
      m_intn = !((m_sts != '0) || (m_st == S_FS));
      m_sts  = (m_sts & ~i_err_clr) | uq;
      m_st   = nst;
      m_rec  = nrec;
      for (int i = 0; i < N; i++) run_len[i] = i_err[i] ? run_len[i] + 1 : 0;
   endfunction

   task automatic cyc(input int n);
      for (int k = 0; k < n; k++) begin
         m_step();
         @(posedge i_clk);
         #1;
         chk("st",    32'(o_st),       32'(m_st));
         chk("sts",   32'(o_err_sts),  32'(m_sts));
         chk("pwm",   32'(o_pwm_en),   32'(m_pwm));
         chk("fsafe", 32'(o_fsafe_en), 32'(m_fs));
         chk("int_n", 32'(o_int_n),    32'(m_intn));
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_st"},    32'(o_st),       32'd0);
      chk({tag, "_sts"},   32'(o_err_sts),  32'd0);
      chk({tag, "_pwm"},   32'(o_pwm_en),   32'd0);
      chk({tag, "_fsafe"}, 32'(o_fsafe_en), 32'd0);
      chk({tag, "_int_n"}, 32'(o_int_n),    32'd1);
   endtask

   initial begin
      int b;
      i_rst_n     = 1'b0;
      i_run_en    = 1'b0;
      i_fsenb_n   = 1'b1;
      i_err       = '0;
      i_err_mask  = '0;
      i_err_fatal = '0;
      i_err_clr   = '0;
      repeat (2) @(posedge i_clk);
      #1;
      chk_reset("rst");
      m_reset();
      i_rst_n = 1'b1;

      i_run_en = 1'b1;
      cyc(1); chk("run_st", 32'(o_st), 32'd1);
      cyc(1); chk("run_pwm", 32'(o_pwm_en), 32'd1);

      i_err[3] = 1'b1; cyc(3);
      i_err[3] = 1'b0; cyc(2);
      chk("glitch_st", 32'(o_st), 32'd1);
      chk("glitch_sts", 32'(o_err_sts), 32'd0);
      i_err[3] = 1'b1; cyc(4);
      chk("deb4_st", 32'(o_st), 32'd1);
      cyc(1);
      chk("flt_st", 32'(o_st), 32'd2);
      chk("flt_sts3", 32'(o_err_sts[3]), 32'd1);
      cyc(1);
      chk("flt_pwm", 32'(o_pwm_en), 32'd0);
      chk("flt_int", 32'(o_int_n), 32'd0);

      i_err[3] = 1'b0; cyc(2);
      chk("rec_st", 32'(o_st), 32'd3);
      cyc(7); chk("rec7_st", 32'(o_st), 32'd3);
      cyc(1); chk("rec8_st", 32'(o_st), 32'd1);

      i_err[3] = 1'b1; cyc(5);
      i_err[3] = 1'b0; cyc(2);
      chk("rec2_st", 32'(o_st), 32'd3);
      i_err[3] = 1'b1; cyc(4);
      chk("rere_st", 32'(o_st), 32'd3);
      cyc(1); chk("rere_flt", 32'(o_st), 32'd2);
      i_err[3] = 1'b0; cyc(2);
      cyc(7); chk("recclr_st", 32'(o_st), 32'd3);
      cyc(1); chk("recclr_run", 32'(o_st), 32'd1);
      i_err_clr[3] = 1'b1; cyc(1);
      i_err_clr = '0;

      i_err_fatal[5] = 1'b1;
      i_err[5] = 1'b1; cyc(5);
      i_err[5] = 1'b0; cyc(4);
      chk("fatal_hold", 32'(o_st), 32'd2);
      i_err_clr[5] = 1'b1; cyc(1);
      i_err_clr = '0; cyc(1);
      chk("fatal_rec", 32'(o_st), 32'd3);
      chk("fatal_int", 32'(o_int_n), 32'd1);
      cyc(8);

      i_err[1] = 1'b1; cyc(4);
      i_fsenb_n = 1'b0; cyc(1);
      chk("fs_st", 32'(o_st), 32'd4);
      cyc(1); chk("fs_en", 32'(o_fsafe_en), 32'd1);
      i_fsenb_n = 1'b1; i_err[1] = 1'b0; cyc(2);
      chk("fs_exit", 32'(o_st), 32'd0);
      i_err_clr = '1; cyc(1);
      i_err_clr = '0; cyc(1);

      i_err_mask[7] = 1'b1; i_err[7] = 1'b1; cyc(8);
      chk("mask_sts", 32'(o_err_sts), 32'd0);
      chk("mask_st", 32'(o_st), 32'd1);
      i_err[7] = 1'b0; cyc(2);
      i_err_mask[7] = 1'b0;

      i_err[2] = 1'b1; cyc(4);
      i_err_clr[2] = 1'b1; cyc(1);
      i_err_clr = '0;
      chk("setclr_sts2", 32'(o_err_sts[2]), 32'd1);
      i_err_mask[2] = 1'b1; cyc(2);
      chk("maskset_sts2", 32'(o_err_sts[2]), 32'd1);
      i_err_mask[2] = 1'b0; cyc(1);
      chk("prerst_st", 32'(o_st), 32'd2);

      i_rst_n = 1'b0; #2;
      chk_reset("midrst");
      m_reset();
      #2 i_rst_n = 1'b1;
      cyc(4); chk("postrst_st", 32'(o_st), 32'd1);
      cyc(1); chk("postrst_flt", 32'(o_st), 32'd2);
      i_err = '0; i_err_clr = '1; cyc(2);
      i_err_clr = '0;

      for (int c = 0; c < 500; c++) begin
         if ($urandom_range(0, 3) == 0) begin
            b = $urandom_range(0, N - 1);
            i_err[b] = ~i_err[b];
         end
         if ($urandom_range(0, 29) == 0) begin
            b = $urandom_range(0, N - 1);
            i_err_mask[b] = ~i_err_mask[b];
         end
         if ($urandom_range(0, 29) == 0) begin
            b = $urandom_range(0, N - 1);
            i_err_fatal[b] = ~i_err_fatal[b];
         end
         i_err_clr = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
         if ($urandom_range(0, 49) == 0) i_fsenb_n = ~i_fsenb_n;
         if ($urandom_range(0, 24) == 0) i_run_en = ~i_run_en;
         cyc(1);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
